// File: rtl/opcode_assembler.sv
// opcode_assembler: deserialises fixed-width chunks into wide opcodes and queues them for a valid/ready consumer
module opcode_assembler #(
    parameter int IN_WIDTH   = 8,
    parameter int CHUNKS     = 2,
    parameter int FIFO_DEPTH = 4,
    localparam int OP_WIDTH  = IN_WIDTH * CHUNKS,
    localparam int CW        = (CHUNKS > 1) ? $clog2(CHUNKS) : 1,
    localparam int LW        = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    input  logic [IN_WIDTH-1:0] in_data,
    input  logic                resync,
    output logic                out_valid,
    output logic [OP_WIDTH-1:0] out_opcode,
    input  logic                out_ready,
    output logic [LW-1:0]       level,
    output logic                overflow,
    input  logic                clear_overflow,
    output logic [CW-1:0]       chunk_idx
);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [OP_WIDTH-1:0] sr;
    logic [OP_WIDTH-1:0] word;
    logic [CW-1:0]       idx_base;
    logic                last;
    logic                push;
    logic                pop;
    logic                full;
    logic                wr;
    logic [OP_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]       wp;
    logic [AW-1:0]       rp;

    assign out_valid  = level != '0;
    assign out_opcode = mem[rp];

    // resync restarts the count so a chunk arriving with it is treated as chunk 0
    always_comb begin
        idx_base = resync ? '0 : chunk_idx;
        last     = idx_base == CW'(CHUNKS - 1);
        word     = ((resync ? '0 : sr) << IN_WIDTH) | OP_WIDTH'(in_data);
        push     = in_valid && last;
        pop      = out_valid && out_ready;
        full     = level == LW'(FIFO_DEPTH);
        wr       = push && (!full || pop);
    end

    // chunk counter and shift register; first chunk migrates to the MSBs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            chunk_idx <= '0;
            sr        <= '0;
        end else if (in_valid) begin
            chunk_idx <= last ? '0 : idx_base + 1'b1;
            sr        <= word;
        end else if (resync) begin
            chunk_idx <= '0;
            sr        <= '0;
        end
    end

    // pointers, occupancy and sticky overflow; a dropped push takes priority over clear
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wp       <= '0;
            rp       <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr) wp <= wp + 1'b1;
            if (pop) rp <= rp + 1'b1;
            level    <= level + LW'(wr) - LW'(pop);
            overflow <= (push && !wr) ? 1'b1 : clear_overflow ? 1'b0 : overflow;
        end
    end

    // storage is not reset; the pointers define which entries are meaningful
    always_ff @(posedge clk) begin
        if (rst_n && wr) mem[wp] <= word;
    end
endmodule

// File: tb/tb_opcode_assembler.sv
// tb_opcode_assembler: vector table, directed corner cases and randomized model check for opcode_assembler
module tb_opcode_assembler;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        resync = 1'b0;
    logic        out_valid;
    logic [15:0] out_opcode;
    logic        out_ready = 1'b0;
    logic [2:0]  level;
    logic        overflow;
    logic        clear_overflow = 1'b0;
    logic [0:0]  chunk_idx;

    logic        p_in_valid = 1'b0;
    logic [3:0]  p_in_data = 4'h0;
    logic        p_out_valid;
    logic [11:0] p_out_opcode;
    logic [1:0]  p_level;
    logic        p_overflow;
    logic [1:0]  p_chunk_idx;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    opcode_assembler dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .resync(resync),
        .out_valid(out_valid), .out_opcode(out_opcode), .out_ready(out_ready), .level(level),
        .overflow(overflow), .clear_overflow(clear_overflow), .chunk_idx(chunk_idx)
    );

    opcode_assembler #(.IN_WIDTH(4), .CHUNKS(3), .FIFO_DEPTH(2)) dut_p (
        .clk(clk), .rst_n(rst_n), .in_valid(p_in_valid), .in_data(p_in_data), .resync(1'b0),
        .out_valid(p_out_valid), .out_opcode(p_out_opcode), .out_ready(1'b0), .level(p_level),
        .overflow(p_overflow), .clear_overflow(1'b0), .chunk_idx(p_chunk_idx)
    );

    typedef struct packed {
        logic        iv;
        logic [7:0]  d;
        logic        rs;
        logic        rdy;
        logic        clr;
        logic        e_valid;
        logic [15:0] e_op;
        logic [2:0]  e_lvl;
        logic        e_ovf;
        logic        e_idx;
    } vec_t;

    vec_t vt[13];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        resync = 1'b0;
        clear_overflow = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic send(input logic [7:0] d, input logic rdy);
        in_valid = 1'b1;
        in_data = d;
        out_ready = rdy;
        tick();
        in_valid = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic push_op(input logic [15:0] op);
        send(op[15:8], 1'b0);
        send(op[7:0], 1'b0);
    endtask

    logic [15:0] mq[$];
    logic [7:0]  mp[$];
    logic        movf;
    logic        m_push;
    logic        m_pop;
    logic [15:0] m_word;

    initial begin
        vt[0]  = '{1'b1, 8'hAB, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 3'd0, 1'b0, 1'b1};
        vt[1]  = '{1'b1, 8'hCD, 1'b0, 1'b1, 1'b0, 1'b1, 16'hABCD, 3'd1, 1'b0, 1'b0};
        vt[2]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 3'd0, 1'b0, 1'b0};
        vt[3]  = '{1'b1, 8'h11, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 3'd0, 1'b0, 1'b1};
        vt[4]  = '{1'b1, 8'h22, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 3'd0, 1'b0, 1'b1};
        vt[5]  = '{1'b1, 8'h33, 1'b0, 1'b1, 1'b0, 1'b1, 16'h2233, 3'd1, 1'b0, 1'b0};
        vt[6]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 3'd0, 1'b0, 1'b0};
        vt[7]  = '{1'b1, 8'h44, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 3'd0, 1'b0, 1'b1};
        vt[8]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 3'd0, 1'b0, 1'b0};
        vt[9]  = '{1'b1, 8'h55, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 3'd0, 1'b0, 1'b1};
        vt[10] = '{1'b1, 8'h66, 1'b0, 1'b0, 1'b0, 1'b1, 16'h5566, 3'd1, 1'b0, 1'b0};
        vt[11] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 16'h5566, 3'd1, 1'b0, 1'b0};
        vt[12] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 3'd0, 1'b0, 1'b0};

        do_reset();
        chk("reset_valid", 32'(out_valid), 32'd0);
        chk("reset_level", 32'(level), 32'd0);
        chk("reset_ovf", 32'(overflow), 32'd0);
        chk("reset_idx", 32'(chunk_idx), 32'd0);
        chk("p_reset_idx", 32'(p_chunk_idx), 32'd0);

        for (int i = 0; i < 3; i++) begin
            p_in_valid = 1'b1;
            p_in_data = 4'(i + 1);
            tick();
            chk("p_idx", 32'(p_chunk_idx), 32'((i + 1) % 3));
        end
        p_in_valid = 1'b0;
        chk("p_valid", 32'(p_out_valid), 32'd1);
        chk("p_opcode", 32'(p_out_opcode), 32'h123);
        chk("p_level", 32'(p_level), 32'd1);

        for (int i = 0; i < 13; i++) begin
            in_valid = vt[i].iv;
            in_data = vt[i].d;
            resync = vt[i].rs;
            out_ready = vt[i].rdy;
            clear_overflow = vt[i].clr;
            tick();
            chk("vec_valid", 32'(out_valid), 32'(vt[i].e_valid));
            chk("vec_level", 32'(level), 32'(vt[i].e_lvl));
            chk("vec_ovf", 32'(overflow), 32'(vt[i].e_ovf));
            chk("vec_idx", 32'(chunk_idx), 32'(vt[i].e_idx));
            if (vt[i].e_valid) chk("vec_opcode", 32'(out_opcode), 32'(vt[i].e_op));
        end
        in_valid = 1'b0;
        resync = 1'b0;
        out_ready = 1'b0;

        do_reset();
        for (int i = 1; i <= 5; i++) push_op(16'(i));
        chk("ovf_level", 32'(level), 32'd4);
        chk("ovf_flag", 32'(overflow), 32'd1);
        for (int i = 1; i <= 4; i++) begin
            chk("drain_valid", 32'(out_valid), 32'd1);
            chk("drain_opcode", 32'(out_opcode), 32'(i));
            out_ready = 1'b1;
            tick();
        end
        out_ready = 1'b0;
        chk("drain_level", 32'(level), 32'd0);
        chk("drain_valid_end", 32'(out_valid), 32'd0);
        chk("drain_ovf_held", 32'(overflow), 32'd1);
        clear_overflow = 1'b1;
        tick();
        clear_overflow = 1'b0;
        chk("ovf_cleared", 32'(overflow), 32'd0);

        for (int i = 1; i <= 4; i++) push_op(16'(i));
        send(8'h00, 1'b0);
        clear_overflow = 1'b1;
        send(8'h06, 1'b0);
        clear_overflow = 1'b0;
        chk("set_wins", 32'(overflow), 32'd1);
        chk("set_wins_level", 32'(level), 32'd4);

        do_reset();
        for (int i = 1; i <= 4; i++) push_op(16'(i));
        send(8'h00, 1'b0);
        send(8'h05, 1'b1);
        chk("full_pp_level", 32'(level), 32'd4);
        chk("full_pp_ovf", 32'(overflow), 32'd0);
        for (int i = 2; i <= 5; i++) begin
            chk("full_pp_opcode", 32'(out_opcode), 32'(i));
            out_ready = 1'b1;
            tick();
        end
        out_ready = 1'b0;
        chk("full_pp_empty", 32'(level), 32'd0);

        do_reset();
        push_op(16'h1111);
        push_op(16'h2222);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_opcode", 32'(out_opcode), 32'h1111);
            chk("bp_level", 32'(level), 32'd2);
        end
        send(8'h77, 1'b0);
        chk("bp_half_idx", 32'(chunk_idx), 32'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("rst_mid_level", 32'(level), 32'd0);
        chk("rst_mid_valid", 32'(out_valid), 32'd0);
        chk("rst_mid_idx", 32'(chunk_idx), 32'd0);
        send(8'h5A, 1'b0);
        send(8'hA5, 1'b0);
        chk("post_rst_valid", 32'(out_valid), 32'd1);
        chk("post_rst_opcode", 32'(out_opcode), 32'h5AA5);

        do_reset();
        mq.delete();
        mp.delete();
        movf = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            rst_n = ($urandom_range(0, 199) != 0);
            in_valid = ($urandom_range(0, 99) < 60);
            in_data = 8'($urandom);
            resync = ($urandom_range(0, 99) < 6);
            out_ready = ($urandom_range(0, 99) < ((((c / 150) % 2) != 0) ? 80 : 20));
            clear_overflow = ($urandom_range(0, 99) < 4);
            if (!rst_n) begin
                mq.delete();
                mp.delete();
                movf = 1'b0;
            end else begin
                m_pop = (mq.size() > 0) && out_ready;
                m_push = 1'b0;
                m_word = 16'h0;
                if (resync) mp.delete();
                if (in_valid) begin
                    mp.push_back(in_data);
                    if (mp.size() == 2) begin
                        foreach (mp[k]) m_word = (m_word << 8) | 16'(mp[k]);
                        mp.delete();
                        m_push = 1'b1;
                    end
                end
                if (m_pop) void'(mq.pop_front());
                if (m_push && mq.size() >= 4) movf = 1'b1;
                else begin
                    if (m_push) mq.push_back(m_word);
                    if (clear_overflow) movf = 1'b0;
                end
            end
            tick();
            chk("rnd_valid", 32'(out_valid), 32'(mq.size() > 0));
            chk("rnd_level", 32'(level), 32'(mq.size()));
            chk("rnd_ovf", 32'(overflow), 32'(movf));
            chk("rnd_idx", 32'(chunk_idx), 32'(mp.size()));
            if (mq.size() > 0) chk("rnd_opcode", 32'(out_opcode), 32'(mq[0]));
        end
        rst_n = 1'b1;
        in_valid = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
